// File: rtl/mul_arbiter_if.sv
// Operand/response bundle between two requesters, the arbiter and the shared multiplier.
interface mul_arbiter_if;
  localparam int unsigned OP_W   = 8;
  localparam int unsigned PROD_W = 16;

  logic              req0_valid;
  logic              req1_valid;
  logic [OP_W-1:0]   req0_a;
  logic [OP_W-1:0]   req0_b;
  logic [OP_W-1:0]   req1_a;
  logic [OP_W-1:0]   req1_b;
  logic              req0_ready;
  logic              req1_ready;
  logic              mul_start;
  logic [OP_W-1:0]   mul_a;
  logic [OP_W-1:0]   mul_b;
  logic [PROD_W-1:0] mul_product;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [PROD_W-1:0] rsp_product;
  logic              busy;

  // Arbiter side.
  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  mul_product, rsp_ready,
    output req0_ready, req1_ready, mul_start, mul_a, mul_b,
    output rsp_valid, rsp_id, rsp_product, busy
  );

  // Requester / multiplier / consumer side.
  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output mul_product, rsp_ready,
    input  req0_ready, req1_ready, mul_start, mul_a, mul_b,
    input  rsp_valid, rsp_id, rsp_product, busy
  );
endinterface

// File: rtl/mul_arbiter.sv
// Two-requester round-robin front end for a shared sequential 8x8 multiplier.
// One job in flight; the result is held until the consumer accepts it.
module mul_arbiter #(
  parameter int unsigned MUL_CYCLES = 9
) (
  input logic          clk,
  input logic          areset_n,
  mul_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t           state;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic             any_valid;
  logic             grant;
  logic             offer;

  // Grant selection: lone requester wins, ties go to the one not served last.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    grant     = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
    offer     = areset_n && (state == IDLE) && any_valid;
  end

  // Ready goes combinationally to the granted requester only, never during reset.
  assign bus.req0_ready = offer && !grant;
  assign bus.req1_ready = offer && grant;

  // Job FSM with registered multiplier controls and response.
  always_ff @(posedge clk) begin
    if (!areset_n) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      cnt             <= '0;
      bus.mul_start   <= 1'b0;
      bus.mul_a       <= '0;
      bus.mul_b       <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_id      <= 1'b0;
      bus.rsp_product <= '0;
      bus.busy        <= 1'b0;
    end else begin
      bus.mul_start <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            bus.mul_a     <= grant ? bus.req1_a : bus.req0_a;
            bus.mul_b     <= grant ? bus.req1_b : bus.req0_b;
            bus.rsp_id    <= grant;
            last_grant    <= grant;
            bus.mul_start <= 1'b1;
            bus.busy      <= 1'b1;
            state         <= START;
          end
        end
        START: begin
          cnt   <= CNT_W'(MUL_CYCLES);
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            bus.rsp_product <= bus.mul_product;
            bus.rsp_valid   <= 1'b1;
            state           <= DONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
